lsu: RTL and testbench
======================

# lsu

Load/store unit for the multi-cycle core's MEMORY stage. Driven by the stage FSM's one-hot MEMORY bit. Performs one aligned byte, halfword or word access over a req/ack data bus, and sign- or zero-extends load data for WRITE_BACK. Raises `stall` to hold the stage FSM in MEMORY until the bus access completes.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of `addr` and `mem_addr`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  level; stage FSM MEMORY bit, high for the whole stage.
- `is_store`  in  1  1 = store, 0 = load; sampled with `start` in IDLE.
- `funct3`  in  3  access type, RV32I encoding.
- `addr`  in  ADDR_WIDTH  byte address.
- `wdata`  in  32  store data, right-aligned.
- `stall`  out  1  combinational; core holds the stage FSM while high.
- `done`  out  1  access finished; high in DONE/FAULT states.
- `fault`  out  1  misaligned or illegal funct3; high in FAULT state.
- `rdata`  out  32  extended load result; holds until the next load completes.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, `{addr[ADDR_WIDTH-1:2], 2'b00}`.
- `mem_wstrb`  out  4  byte lane strobes; 0 for loads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  bus completion, single-cycle pulse.
- `mem_rdata`  in  32  load word, valid with `mem_ack`.

## Operation
- States: IDLE, BUS, DONE, FAULT.
- IDLE with `start` = 1:
  - Latch `is_store`, `funct3`, `addr`, `wdata`.
  - Legal and aligned access -> BUS.
  - Otherwise -> FAULT.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: half with `addr[0]` = 1; word with `addr[1:0]` != 0.
- BUS:
  - `mem_req` = 1. Address, `mem_we`, strobes and data come from the latched values and stay stable.
  - `mem_ack` = 1 -> DONE. A load latches extended `mem_rdata` into `rdata` on the same edge.
- DONE / FAULT:
  - `done` = 1. `fault` = 1 only in FAULT.
  - Leave to IDLE when `start` = 0. Stay while `start` remains high, so there is no re-trigger.
- FAULT issues no bus cycle. `rdata` is unchanged.
- Stores:
  - SB: `mem_wdata` = `{4{wdata[7:0]}}`, `mem_wstrb` = `4'b0001 << addr[1:0]`.
  - SH: `mem_wdata` = `{2{wdata[15:0]}}`, `mem_wstrb` = `addr[1]` ? 1100 : 0011.
  - SW: `mem_wdata` = `wdata`, `mem_wstrb` = 1111.
- Loads:
  - Byte lane = `mem_rdata[8*addr[1:0] +: 8]`.
  - Half lane = `mem_rdata[16*addr[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `stall` = (IDLE & `start` & legal & aligned) | BUS.
- `mem_ack` outside BUS is ignored.

## Timing
- Reset values: state IDLE, `rdata` = 0, `mem_req` = 0, `mem_we` = 0, `mem_wstrb` = 0, `stall` = 0, `done` = 0, `fault` = 0.
- `mem_addr` and `mem_wdata` are 0 when not in BUS.
- Cycle 0 (IDLE, `start` rises): `stall` = 1 combinationally.
- Cycle 1: BUS, `mem_req` = 1.
- Ack in cycle k: DONE in cycle k+1 with `stall` = 0. The stage FSM advances at the end of k+1.
- Minimum access is 3 cycles in MEMORY (zero-wait ack in cycle 1).
- Fault path: FAULT in cycle 1, `stall` = 0 in cycle 0. Exactly 2 cycles in MEMORY.
- `reset` during BUS: IDLE on the next edge and `mem_req` drops. A later `mem_ack` is ignored.
- `reset` has priority over `start` and `mem_ack` in the same cycle.
- Inputs changing during BUS have no effect.

## Test plan
- LW from 0x100 with `mem_rdata` = 0xDEADBEEF and ack after 2 wait cycles:
  - `mem_addr` = 0x100, `mem_wstrb` = 0.
  - `stall` high for cycles 0–3, `done` in cycle 4.
  - `rdata` = 0xDEADBEEF.
- LB and LBU at 0x103 with `mem_rdata` = 0x80FF_0000, zero-wait:
  - LB gives `rdata` = 0xFFFFFF80.
  - LBU gives `rdata` = 0x00000080.
- SH at 0x202 with `wdata` = 0x1234ABCD: `mem_wdata` = 0xABCDABCD, `mem_wstrb` = 1100, `mem_we` = 1, `mem_addr` = 0x200.
- LW at 0x101:
  - No `mem_req`; FAULT the next cycle with `fault` = 1 and `done` = 1.
  - `rdata` unchanged.
  - funct3 = 011 faults identically.
- Reset asserted in the second BUS cycle of an SW:
  - `mem_req` = 0 and state IDLE next cycle.
  - A stray `mem_ack` afterwards gives no `done`.
- `start` held high 3 cycles past DONE: `done` stays high, no second `mem_req`. Drop `start`, then IDLE.

Source files
------------

// File: rtl/lsu_bus_if.sv
// Data-bus bundle between the load/store unit and memory.
// The master drives a request held stable until a single-cycle ack.
interface lsu_bus_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// MEMORY-stage load/store unit: one aligned byte/half/word access per stage,
// with load extension and a stall that holds the stage FSM until the bus acks.
module lsu #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic                  done,
    output logic                  fault,
    output logic [31:0]           rdata,
    output logic [1:0]            state_dbg_o,
    lsu_bus_if.master             bus
);
    // Bus handshake: mem_req stays high with stable address/strobes/data
    // until mem_ack pulses for one cycle; an ack outside BUS is ignored.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;

    logic                  legal_in;
    logic                  misaligned_in;
    logic                  access_ok;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [31:0]           load_ext;
    logic [31:0]           st_data;
    logic [3:0]            st_strb;
    logic                  in_bus;

    // Legality is judged on the live inputs since the decision is made in IDLE.
    always_comb begin
        legal_in = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal_in = 1'b1;
            3'b100, 3'b101:         legal_in = ~is_store;
            default:                legal_in = 1'b0;
        endcase
        misaligned_in = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        access_ok = legal_in && !misaligned_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
            end
            if (state_q == S_BUS && bus.mem_ack && !is_store_q) begin
                rdata_q <= load_ext;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = access_ok ? S_BUS : S_FAULT;
                    stall   = access_ok;
                end
            end
            S_BUS: begin
                stall = 1'b1;
                if (bus.mem_ack) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            S_FAULT: begin
                done  = 1'b1;
                fault = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane selection and extension use the latched address and funct3.
    always_comb begin
        byte_lane = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_lane = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_ext = {24'd0, byte_lane};
            3'b101:  load_ext = {16'd0, half_lane};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_data = {4{wdata_q[7:0]}};
                st_strb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                st_data = {2{wdata_q[15:0]}};
                st_strb = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = wdata_q;
                st_strb = 4'b1111;
            end
        endcase
    end

    assign in_bus        = (state_q == S_BUS);
    assign bus.mem_req   = in_bus;
    assign bus.mem_we    = in_bus && is_store_q;
    assign bus.mem_addr  = in_bus ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_wstrb = (in_bus && is_store_q) ? st_strb : 4'b0000;
    assign bus.mem_wdata = (in_bus && is_store_q) ? st_data : 32'd0;
    assign rdata         = rdata_q;
    assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one task per scenario with inline checks and
// hand-computed expected values.
module tb_lsu;
  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [1:0]  state_dbg;

  int total;
  int bad;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUS   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  lsu_bus_if #(.ADDR_WIDTH(32)) bus ();

  lsu #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .fault       (fault),
    .rdata       (rdata),
    .state_dbg_o (state_dbg),
    .bus         (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge; inputs change here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // settle combinational outputs after driving inputs, well before the next edge
  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    cyc(); cyc(); settle();
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    total++; if ({stall, done, fault} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {stall, done, fault}); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 6'd0) begin bad++; $display("FAIL reset_bus got=%b exp=000000", {bus.mem_req, bus.mem_we, bus.mem_wstrb}); end
    total++; if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_lw_wait();
    issue(1'b0, 3'b010, 32'h100, 32'd0); settle();
    total++; if (stall !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL lw_c0 got stall=%b req=%b exp stall=1 req=0", stall, bus.mem_req); end
    cyc(); settle();
    total++; if (bus.mem_req !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL lw_c1 got req=%b stall=%b exp 1/1", bus.mem_req, stall); end
    total++; if (bus.mem_addr !== 32'h100 || bus.mem_wstrb !== 4'b0000 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL lw_bus got addr=%h strb=%b we=%b exp 100/0000/0", bus.mem_addr, bus.mem_wstrb, bus.mem_we); end
    // inputs changing during BUS must not matter
    addr = 32'h0bad; funct3 = 3'b000; is_store = 1'b1;
    cyc(); settle();
    total++; if (stall !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL lw_c2 got stall=%b addr=%h we=%b exp 1/100/0", stall, bus.mem_addr, bus.mem_we); end
    cyc();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; settle();
    total++; if (stall !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL lw_c3 got stall=%b done=%b exp 1/0", stall, done); end
    cyc();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; settle();
    total++; if (done !== 1'b1 || stall !== 1'b0 || fault !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL lw_c4 got done=%b stall=%b fault=%b req=%b exp 1/0/0/0", done, stall, fault, bus.mem_req); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rdata); end
    start = 1'b0;
    cyc(); settle();
    total++; if (state_dbg !== ST_IDLE || done !== 1'b0) begin bad++; $display("FAIL lw_idle got state=%0d done=%b exp 0/0", state_dbg, done); end
  endtask

  task automatic test_loads_ext();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], as[i], 32'd0);
      cyc();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FF_0000; settle();
      total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin bad++; $display("FAIL ext%0d_bus got req=%b addr=%h exp 1/100", i, bus.mem_req, bus.mem_addr); end
      cyc();
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; settle();
      total++; if (done !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL ext%0d_done got done=%b stall=%b exp 1/0", i, done, stall); end
      total++; if (rdata !== exps[i]) begin bad++; $display("FAIL ext%0d_rdata got=%h exp=%h", i, rdata, exps[i]); end
      start = 1'b0;
      cyc();
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] as   [3] = '{32'h202, 32'h201, 32'h204};
    logic [31:0] wds  [3] = '{32'h1234ABCD, 32'hCAFE0077, 32'h89ABCDEF};
    logic [31:0] ewd  [3] = '{32'hABCDABCD, 32'h77777777, 32'h89ABCDEF};
    logic [3:0]  estb [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] eaddr[3] = '{32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, f3s[i], as[i], wds[i]);
      cyc(); settle();
      total++; if (bus.mem_wdata !== ewd[i] || bus.mem_wstrb !== estb[i]) begin bad++; $display("FAIL st%0d_data got wdata=%h strb=%b exp %h/%b", i, bus.mem_wdata, bus.mem_wstrb, ewd[i], estb[i]); end
      total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== eaddr[i] || bus.mem_req !== 1'b1) begin bad++; $display("FAIL st%0d_ctl got we=%b addr=%h req=%b exp 1/%h/1", i, bus.mem_we, bus.mem_addr, bus.mem_req, eaddr[i]); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555AAAA;
      cyc();
      bus.mem_ack = 1'b0; settle();
      total++; if (done !== 1'b1 || rdata !== 32'h000080FF) begin bad++; $display("FAIL st%0d_done got done=%b rdata=%h exp 1/000080ff", i, done, rdata); end
      start = 1'b0;
      cyc();
    end
  endtask

  task automatic test_fault();
    logic [2:0]  f3s[2] = '{3'b010, 3'b011};
    logic [31:0] as [2] = '{32'h101, 32'h100};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, f3s[i], as[i], 32'd0); settle();
      total++; if (stall !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL flt%0d_c0 got stall=%b req=%b exp 0/0", i, stall, bus.mem_req); end
      cyc();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678; settle();
      total++; if (state_dbg !== ST_FAULT || fault !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL flt%0d_c1 got state=%0d fault=%b done=%b exp 3/1/1", i, state_dbg, fault, done); end
      total++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flt%0d_nobus got req=%b stall=%b exp 0/0", i, bus.mem_req, stall); end
      cyc();
      bus.mem_ack = 1'b0; settle();
      total++; if (rdata !== 32'h000080FF || state_dbg !== ST_FAULT) begin bad++; $display("FAIL flt%0d_hold got rdata=%h state=%0d exp 000080ff/3", i, rdata, state_dbg); end
      start = 1'b0;
      cyc(); settle();
      total++; if (state_dbg !== ST_IDLE || fault !== 1'b0) begin bad++; $display("FAIL flt%0d_idle got state=%0d fault=%b exp 0/0", i, state_dbg, fault); end
    end
  endtask

  task automatic test_reset_in_bus();
    issue(1'b1, 3'b010, 32'h300, 32'h11223344);
    cyc(); settle();
    total++; if (state_dbg !== ST_BUS) begin bad++; $display("FAIL rib_c1 got state=%0d exp 1", state_dbg); end
    cyc();
    reset = 1'b1; bus.mem_ack = 1'b1;
    cyc();
    reset = 1'b0; bus.mem_ack = 1'b0; start = 1'b0; settle();
    total++; if (bus.mem_req !== 1'b0 || state_dbg !== ST_IDLE) begin bad++; $display("FAIL rib_drop got req=%b state=%0d exp 0/0", bus.mem_req, state_dbg); end
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack = 1'b0; settle();
    total++; if (done !== 1'b0 || state_dbg !== ST_IDLE) begin bad++; $display("FAIL rib_stray got done=%b state=%0d exp 0/0", done, state_dbg); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rib_rdata got=%h exp=0", rdata); end
  endtask

  task automatic test_hold_start();
    issue(1'b0, 3'b010, 32'h40, 32'd0);
    cyc();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0F0F1234;
    cyc();
    bus.mem_ack = 1'b0; settle();
    total++; if (done !== 1'b1 || rdata !== 32'h0F0F1234) begin bad++; $display("FAIL hold_done got done=%b rdata=%h exp 1/0f0f1234", done, rdata); end
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      total++; if (done !== 1'b1 || bus.mem_req !== 1'b0 || state_dbg !== ST_DONE) begin bad++; $display("FAIL hold%0d got done=%b req=%b state=%0d exp 1/0/2", i, done, bus.mem_req, state_dbg); end
    end
    start = 1'b0;
    cyc(); settle();
    total++; if (state_dbg !== ST_IDLE || done !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL hold_idle got state=%0d done=%b req=%b exp 0/0/0", state_dbg, done, bus.mem_req); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_lw_wait();
    test_loads_ext();
    test_stores();
    test_fault();
    test_reset_in_bus();
    test_hold_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
